// File: rtl/parity_frame_rx.sv
// parity_frame_rx: bit-strobed serial frame receiver (start, N data LSB first,
// even-parity bit, stop). Delivers each word with parity/framing flags.
// Optional: define PARITY_FRAME_RX_ERRCNT_EN to add a saturating 8-bit
// err_count of frames that carried a parity or framing error.
module parity_frame_rx #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         bit_en,
  input  logic         rx_in,
  output logic [N-1:0] data_out,
  output logic         data_valid,
  output logic         parity_err,
  output logic         frame_err,
  output logic         busy
`ifdef PARITY_FRAME_RX_ERRCNT_EN
  ,output logic [7:0]  err_count
`endif
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [N-1:0]    shreg, sh_next;
  logic            par_bit;
  logic            perr_nxt;

  // Right shift with the new bit entering at the MSB; N=1 degenerates to a copy.
  generate
    if (N == 1) begin : g_sh1
      assign sh_next = rx_in;
    end else begin : g_shn
      assign sh_next = {rx_in, shreg[N-1:1]};
    end
  endgenerate

  assign perr_nxt = (^shreg) != par_bit;
  assign busy     = (state != IDLE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; only a strobe may move the FSM.
  always_comb begin
    state_nxt = state;
    if (bit_en) begin
      case (state)
        IDLE:    if (!rx_in) state_nxt = DATA;
        DATA:    if (cnt == CW'(N - 1)) state_nxt = PARITY;
        PARITY:  state_nxt = STOP;
        STOP:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Datapath: shift/count, capture parity, publish word and flags at STOP.
  // data_valid self-clears every clock so the pulse is one cycle wide even
  // when strobes are sparse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
`ifdef PARITY_FRAME_RX_ERRCNT_EN
      err_count  <= 8'd0;
`endif
    end else begin
      data_valid <= 1'b0;
      if (bit_en) begin
        case (state)
          IDLE: begin
            if (!rx_in) begin
              shreg <= '0;
              cnt   <= '0;
            end
          end
          DATA: begin
            shreg <= sh_next;
            cnt   <= cnt + 1'b1;
          end
          PARITY: par_bit <= rx_in;
          STOP: begin
            data_out   <= shreg;
            parity_err <= perr_nxt;
            frame_err  <= ~rx_in;
            data_valid <= 1'b1;
`ifdef PARITY_FRAME_RX_ERRCNT_EN
            // One count per bad frame, saturating.
            if ((perr_nxt || !rx_in) && err_count != 8'hFF)
              err_count <= err_count + 8'd1;
`endif
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_parity_frame_rx.sv
// Directed bench for parity_frame_rx (N=4): reset, parity, framing, strobe
// gaps, back-to-back frames and, when enabled, the error counter.
module tb_parity_frame_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       bit_en;
  logic       rx_in;
  logic [3:0] data_out;
  logic       data_valid, parity_err, frame_err, busy;
`ifdef PARITY_FRAME_RX_ERRCNT_EN
  logic [7:0] err_count;
  int         ec_exp = 0;
`endif

  int total = 0;
  int bad   = 0;
  time t1, t2;

  always #5 clk = ~clk;

  parity_frame_rx #(.N(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .bit_en     (bit_en),
    .rx_in      (rx_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
`ifdef PARITY_FRAME_RX_ERRCNT_EN
    ,.err_count (err_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One strobe, optionally preceded by gap non-strobe cycles of line noise.
  task automatic send_bit(input logic b, input int gap);
    for (int g = 0; g < gap; g++) begin
      @(negedge clk); bit_en = 1'b0; rx_in = 1'($urandom_range(0, 1));
    end
    @(negedge clk); bit_en = 1'b1; rx_in = b;
    @(posedge clk);
  endtask

  // Returns #1 after the stop-bit edge.
  task automatic send_frame(input logic [3:0] d, input logic p, input logic s, input int gap);
    send_bit(1'b0, gap);
    #1 chk("busy_after_start", busy, 1'b1);
    for (int i = 0; i < 4; i++) send_bit(d[i], gap);
    send_bit(p, gap);
    send_bit(s, gap);
    #1;
  endtask

  task automatic check_frame(input string tag, input logic [3:0] ed, input logic ep, input logic ef);
    chk({tag, "_valid"}, data_valid, 1'b1);
    chk({tag, "_data"},  data_out, ed);
    chk({tag, "_perr"},  parity_err, ep);
    chk({tag, "_ferr"},  frame_err, ef);
    chk({tag, "_busy"},  busy, 1'b0);
`ifdef PARITY_FRAME_RX_ERRCNT_EN
    if ((ep || ef) && ec_exp < 255) ec_exp++;
    chk({tag, "_errcnt"}, err_count, ec_exp);
`endif
  endtask

  // Drop the strobe and confirm the valid pulse was a single cycle.
  task automatic idle_chk(input string tag);
    @(negedge clk); bit_en = 1'b0; rx_in = 1'b1;
    @(posedge clk); #1 chk({tag, "_valid_1cyc"}, data_valid, 1'b0);
  endtask

  initial begin
    rst = 1'b1; bit_en = 1'b0; rx_in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data",  data_out, 4'h0);
    chk("rst_valid", data_valid, 1'b0);
    chk("rst_perr",  parity_err, 1'b0);
    chk("rst_ferr",  frame_err, 1'b0);
    chk("rst_busy",  busy, 1'b0);
`ifdef PARITY_FRAME_RX_ERRCNT_EN
    chk("rst_errcnt", err_count, 8'd0);
`endif
    @(negedge clk); rst = 1'b0;

    // Parity: 0111 has three ones -> parity 1 is correct.
    send_frame(4'b0111, 1'b1, 1'b1, 0); check_frame("p0111_ok", 4'b0111, 1'b0, 1'b0);
    idle_chk("p0111_ok");

    // Reset mid-DATA: outputs clear at once, partial frame is dropped.
    send_bit(1'b0, 0); send_bit(1'b1, 0); send_bit(1'b1, 0);
    #3 rst = 1'b1;
    #1;
    chk("midrst_data",  data_out, 4'h0);
    chk("midrst_valid", data_valid, 1'b0);
    chk("midrst_perr",  parity_err, 1'b0);
    chk("midrst_busy",  busy, 1'b0);
`ifdef PARITY_FRAME_RX_ERRCNT_EN
    ec_exp = 0;
`endif
    @(negedge clk); rst = 1'b0; bit_en = 1'b1; rx_in = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("midrst_no_valid", data_valid, 1'b0);
    chk("midrst_idle", busy, 1'b0);

    // First frame: start,0011 LSB first (1,1,0,0), parity 0, stop 1.
    send_frame(4'b0011, 1'b0, 1'b1, 0); check_frame("f0011", 4'b0011, 1'b0, 1'b0);
    idle_chk("f0011");

    // Parity error, then a 4-ones word with parity 0 is clean.
    send_frame(4'b0111, 1'b0, 1'b1, 0); check_frame("p0111_bad", 4'b0111, 1'b1, 1'b0);
    idle_chk("p0111_bad");
    send_frame(4'b1111, 1'b0, 1'b1, 0); check_frame("p1111", 4'b1111, 1'b0, 1'b0);
    idle_chk("p1111");

    // Framing error, good parity; then a clean frame clears both flags.
    send_frame(4'b0001, 1'b1, 1'b0, 0); check_frame("ferr", 4'b0001, 1'b0, 1'b1);
    idle_chk("ferr");
    send_frame(4'b0000, 1'b0, 1'b1, 0); check_frame("clr", 4'b0000, 1'b0, 1'b0);
    idle_chk("clr");

    // Sparse strobes (every 3rd cycle) with line noise between them.
    send_frame(4'b1010, 1'b0, 1'b1, 2); check_frame("gap_prev", 4'b1010, 1'b0, 1'b0);
    idle_chk("gap_prev");
    send_frame(4'b0011, 1'b0, 1'b1, 2);
    check_frame("gap", 4'b0011, 1'b0, 1'b0);
    idle_chk("gap");

    // Back-to-back with continuous strobe: valid pulses 7 cycles apart.
    send_frame(4'b0011, 1'b0, 1'b1, 0); check_frame("b2b_a", 4'b0011, 1'b0, 1'b0);
    t1 = $time;
    send_frame(4'b1111, 1'b0, 1'b1, 0); check_frame("b2b_b", 4'b1111, 1'b0, 1'b0);
    t2 = $time;
    chk("b2b_spacing", 32'(t2 - t1), 32'd70);
    idle_chk("b2b");

`ifdef PARITY_FRAME_RX_ERRCNT_EN
    // 0001 with parity 0 and stop 0: both errors, one count each, saturating.
    for (int i = 0; i < 300; i++) begin
      send_frame(4'b0001, 1'b0, 1'b0, 0);
      check_frame("sat", 4'b0001, 1'b1, 1'b1);
    end
    idle_chk("sat");
    chk("sat_final", err_count, 8'd255);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop if something wedges.
  initial begin
    #500000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
